// File: rtl/fifo_write_sched_if.sv
// Requester/FIFO-side signal bundle for the FIFO write scheduler.
// The master modport is the scheduler; slave is the requesters plus the FIFO.
interface fifo_write_sched_if #(
  parameter int DW = 32
);
  logic          enable;
  logic          full;
  logic          req0;
  logic [DW-1:0] data0;
  logic          ack0;
  logic          req1;
  logic [DW-1:0] data1;
  logic          ack1;
  logic [DW-1:0] wdata;
  logic          writeen;
  logic [15:0]   wrcount;

  modport master (
    input  enable, full, req0, data0, req1, data1,
    output ack0, ack1, wdata, writeen, wrcount
  );

  modport slave (
    output enable, full, req0, data0, req1, data1,
    input  ack0, ack1, wdata, writeen, wrcount
  );
endinterface

// File: rtl/fifo_write_sched.sv
// Round-robin scheduler sharing one FIFO write port between two requesters,
// issuing one registered active-low strobe per word with a GAP-cycle idle gap.
module fifo_write_sched #(
  parameter int DW  = 32,
  parameter int GAP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_write_sched_if.master bus
);
  typedef enum logic [1:0] {IDLE, WRITE, GAP_S} state_t;

  localparam logic [15:0] GAP_INIT = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

  state_t        state, state_n;
  logic [15:0]   gap_cnt;
  logic [15:0]   wrcount_q;
  logic [DW-1:0] wdata_q;
  logic          last;
  logic          writeen_q;
  logic          ack0_q, ack1_q;
  logic          issue;
  logic          winner;

  // Tie goes to whoever was not granted last; a lone requester always wins.
  assign winner = ~(bus.req0 & (~bus.req1 | last));

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable && !bus.full && (bus.req0 || bus.req1)) begin
          issue   = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE:   state_n = (GAP > 0) ? GAP_S : IDLE;
      GAP_S:   if (gap_cnt == 16'd0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= 16'd0;
      wrcount_q <= 16'd0;
      wdata_q   <= '0;
      last      <= 1'b1;
      writeen_q <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
    end else begin
      state     <= state_n;
      writeen_q <= ~issue;
      ack0_q    <= issue & ~winner;
      ack1_q    <= issue & winner;
      if (issue) begin
        wdata_q <= winner ? bus.data1 : bus.data0;
        last    <= winner;
      end
      // Count on WRITE exit; the gap counter loads at the same point.
      if (state == WRITE) begin
        wrcount_q <= wrcount_q + 16'd1;
        gap_cnt   <= GAP_INIT;
      end else if (state == GAP_S && gap_cnt != 16'd0) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
    end
  end

  assign bus.wdata   = wdata_q;
  assign bus.writeen = writeen_q;
  assign bus.ack0    = ack0_q;
  assign bus.ack1    = ack1_q;
  assign bus.wrcount = wrcount_q;
endmodule

// File: tb/tb_fifo_write_sched.sv
// Directed bench for fifo_write_sched: one instance with GAP=2, one with GAP=0.
module tb_fifo_write_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_write_sched_if #(.DW(32)) bus  ();
  fifo_write_sched_if #(.DW(32)) bus0 ();

  fifo_write_sched #(.DW(32), .GAP(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  fifo_write_sched #(.DW(32), .GAP(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));

  task automatic idle_inputs;
    bus.enable  = 1'b1; bus.full  = 1'b0; bus.req0  = 1'b0; bus.req1  = 1'b0;
    bus.data0   = '0;   bus.data1 = '0;
    bus0.enable = 1'b1; bus0.full = 1'b0; bus0.req0 = 1'b0; bus0.req1 = 1'b0;
    bus0.data0  = '0;   bus0.data1 = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.writeen !== 1'b1) begin errors++; $display("FAIL reset_writeen: got %b want 1", bus.writeen); end
    checks++; if ({bus.ack1, bus.ack0} !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", {bus.ack1, bus.ack0}); end
    checks++; if (bus.wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.wdata); end
    checks++; if (bus.wrcount !== 16'h0) begin errors++; $display("FAIL reset_wrcount: got %h want 0", bus.wrcount); end
    checks++; if (bus0.writeen !== 1'b1) begin errors++; $display("FAIL reset_writeen_g0: got %b want 1", bus0.writeen); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    int nlow;
    do_reset();
    bus.data0 = 32'h5; bus.req0 = 1'b1;
    @(negedge clk);
    checks++; if (bus.writeen !== 1'b0) begin errors++; $display("FAIL single_writeen: got %b want 0", bus.writeen); end
    checks++; if (bus.wdata !== 32'h5) begin errors++; $display("FAIL single_wdata: got %h want 5", bus.wdata); end
    checks++; if ({bus.ack1, bus.ack0} !== 2'b01) begin errors++; $display("FAIL single_ack: got %b want 01", {bus.ack1, bus.ack0}); end
    bus.req0 = 1'b0;
    nlow = 0;
    repeat (8) begin @(negedge clk); if (bus.writeen === 1'b0) nlow++; end
    checks++; if (nlow !== 0) begin errors++; $display("FAIL single_extra_writes: got %0d want 0", nlow); end
    checks++; if (bus.wrcount !== 16'd1) begin errors++; $display("FAIL single_wrcount: got %0d want 1", bus.wrcount); end
  endtask

  task automatic test_round_robin;
    int nw, last_cyc, g;
    do_reset();
    bus.data0 = 32'hA0; bus.data1 = 32'hB1;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    nw = 0; last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && nw < 6; cyc++) begin
      @(negedge clk);
      if (bus.writeen === 1'b0) begin
        g = nw % 2;
        checks++; if ({bus.ack1, bus.ack0} !== ((g == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL rr_grant%0d: got ack %b want requester %0d", nw, {bus.ack1, bus.ack0}, g); end
        checks++; if (bus.wdata !== ((g == 1) ? 32'hB1 : 32'hA0)) begin
          errors++; $display("FAIL rr_wdata%0d: got %h", nw, bus.wdata); end
        checks++; if ((cyc - last_cyc) !== ((nw == 0) ? 1 : 4)) begin
          errors++; $display("FAIL rr_spacing%0d: got %0d want %0d", nw, cyc - last_cyc, (nw == 0) ? 1 : 4); end
        last_cyc = cyc;
        nw++;
      end
    end
    checks++; if (nw !== 6) begin errors++; $display("FAIL rr_timeout: got %0d writes want 6", nw); end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    checks++; if (bus.wrcount !== 16'd6) begin errors++; $display("FAIL rr_wrcount: got %0d want 6", bus.wrcount); end
  endtask

  task automatic test_gap0;
    int nw, last_cyc;
    do_reset();
    bus0.data1 = 32'd100; bus0.req1 = 1'b1;
    nw = 0; last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && nw < 8; cyc++) begin
      @(negedge clk);
      if (bus0.writeen === 1'b0) begin
        checks++; if ({bus0.ack1, bus0.ack0} !== 2'b10) begin
          errors++; $display("FAIL g0_ack%0d: got %b want 10", nw, {bus0.ack1, bus0.ack0}); end
        checks++; if (bus0.wdata !== 32'(100 + nw)) begin
          errors++; $display("FAIL g0_wdata%0d: got %0d want %0d", nw, bus0.wdata, 100 + nw); end
        checks++; if ((cyc - last_cyc) !== ((nw == 0) ? 1 : 2)) begin
          errors++; $display("FAIL g0_spacing%0d: got %0d want %0d", nw, cyc - last_cyc, (nw == 0) ? 1 : 2); end
        last_cyc = cyc;
        nw++;
        bus0.data1 = bus0.data1 + 32'd1;
      end
    end
    checks++; if (nw !== 8) begin errors++; $display("FAIL g0_timeout: got %0d writes want 8", nw); end
    bus0.req1 = 1'b0;
    @(negedge clk);
    checks++; if (bus0.wrcount !== 16'd8) begin errors++; $display("FAIL g0_wrcount: got %0d want 8", bus0.wrcount); end
  endtask

  task automatic test_full_enable;
    int nlow, nack;
    do_reset();
    bus.full = 1'b1; bus.data0 = 32'h77; bus.req0 = 1'b1;
    nlow = 0; nack = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.writeen === 1'b0) nlow++;
      if (bus.ack0 !== 1'b0 || bus.ack1 !== 1'b0) nack++;
    end
    checks++; if (nlow !== 0) begin errors++; $display("FAIL full_blocks_write: got %0d low cycles want 0", nlow); end
    checks++; if (nack !== 0) begin errors++; $display("FAIL full_blocks_ack: got %0d ack cycles want 0", nack); end
    bus.full = 1'b0;
    @(negedge clk);
    checks++; if (bus.writeen !== 1'b0) begin errors++; $display("FAIL full_release_writeen: got %b want 0", bus.writeen); end
    checks++; if (bus.wdata !== 32'h77) begin errors++; $display("FAIL full_release_wdata: got %h want 77", bus.wdata); end
    checks++; if (bus.ack0 !== 1'b1) begin errors++; $display("FAIL full_release_ack0: got %b want 1", bus.ack0); end
    bus.data0 = 32'h78;
    @(negedge clk);
    bus.enable = 1'b0;
    nlow = 0;
    repeat (10) begin @(negedge clk); if (bus.writeen === 1'b0) nlow++; end
    checks++; if (nlow !== 0) begin errors++; $display("FAIL enable_hold: got %0d low cycles want 0", nlow); end
    bus.enable = 1'b1;
    @(negedge clk);
    checks++; if (bus.writeen !== 1'b0) begin errors++; $display("FAIL enable_resume_writeen: got %b want 0", bus.writeen); end
    checks++; if (bus.wdata !== 32'h78) begin errors++; $display("FAIL enable_resume_wdata: got %h want 78", bus.wdata); end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++; if (bus.wrcount !== 16'd2) begin errors++; $display("FAIL enable_wrcount: got %0d want 2", bus.wrcount); end
  endtask

  task automatic test_reset_mid_write;
    do_reset();
    bus.data0 = 32'h55; bus.req0 = 1'b1;
    @(negedge clk);
    repeat (4) @(negedge clk);
    checks++; if ({bus.writeen, bus.wrcount} !== {1'b0, 16'd1}) begin
      errors++; $display("FAIL midrst_setup: got writeen %b wrcount %0d want 0/1", bus.writeen, bus.wrcount); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.writeen !== 1'b1) begin errors++; $display("FAIL midrst_writeen: got %b want 1", bus.writeen); end
    checks++; if (bus.ack0 !== 1'b0) begin errors++; $display("FAIL midrst_ack0: got %b want 0", bus.ack0); end
    checks++; if (bus.wrcount !== 16'd0) begin errors++; $display("FAIL midrst_wrcount: got %0d want 0", bus.wrcount); end
    @(negedge clk);
    bus.data0 = 32'h66;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.writeen !== 1'b0) begin errors++; $display("FAIL midrst_regrant_writeen: got %b want 0", bus.writeen); end
    checks++; if (bus.wdata !== 32'h66) begin errors++; $display("FAIL midrst_regrant_wdata: got %h want 66", bus.wdata); end
    checks++; if (bus.ack0 !== 1'b1) begin errors++; $display("FAIL midrst_regrant_ack0: got %b want 1", bus.ack0); end
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++; if (bus.wrcount !== 16'd1) begin errors++; $display("FAIL midrst_wrcount_after: got %0d want 1", bus.wrcount); end
  endtask

  task automatic test_wrap;
    do_reset();
    // Backdoor preload stands in for 65534 real writes.
    dut0.wrcount_q = 16'hFFFE;
    @(negedge clk);
    checks++; if (bus0.wrcount !== 16'hFFFE) begin errors++; $display("FAIL wrap_preload: got %h want fffe", bus0.wrcount); end
    bus0.data0 = 32'h1; bus0.req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus0.wrcount !== 16'hFFFF) begin errors++; $display("FAIL wrap_ffff: got %h want ffff", bus0.wrcount); end
    @(negedge clk);
    bus0.req0 = 1'b0;
    @(negedge clk);
    checks++; if (bus0.wrcount !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", bus0.wrcount); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_gap0();
    test_full_enable();
    test_reset_mid_write();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1, "watchdog expired");
  end
endmodule
